// File: rtl/apb_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_uart_pkg : shared types and helpers for the UART receive path     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package apb_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOW   = 2'd1,
    S_BREAK = 2'd2
  } line_state_e;

  localparam int unsigned CTI_CHARS = 4;

  // start + data + optional parity + stop(s), 7..12
  function automatic logic [3:0] frame_bits(input logic [1:0] bits,
                                            input logic       pen,
                                            input logic       stb);
    frame_bits = 4'd7 + {2'b00, bits} + {3'b000, pen} + {3'b000, stb};
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_uart_rx_frontend_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_uart_rx_frontend_if : pin, config and FIFO-status bundle          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface apb_uart_rx_frontend_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 rx_pad_i;
  logic [DIV_WIDTH-1:0] cfg_div_i;
  logic [1:0]           cfg_bits_i;
  logic                 cfg_parity_en_i;
  logic                 cfg_stop_bits_i;
  logic                 rx_fifo_empty_i;
  logic                 rx_push_i;
  logic                 rx_pop_i;
  logic                 break_clr_i;
  logic                 rx_o;
  logic                 break_o;
  logic                 cti_o;

  modport master (
    output rx_pad_i, cfg_div_i, cfg_bits_i, cfg_parity_en_i, cfg_stop_bits_i,
    output rx_fifo_empty_i, rx_push_i, rx_pop_i, break_clr_i,
    input  rx_o, break_o, cti_o
  );

  modport slave (
    input  rx_pad_i, cfg_div_i, cfg_bits_i, cfg_parity_en_i, cfg_stop_bits_i,
    input  rx_fifo_empty_i, rx_push_i, rx_pop_i, break_clr_i,
    output rx_o, break_o, cti_o
  );
endinterface
`default_nettype wire

// File: rtl/apb_uart_sync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_uart_sync_filter : pad synchroniser plus glitch filter            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module apb_uart_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  wire logic CLK,
  input  wire logic RESETN,
  input  wire logic rx_pad_i,
  output logic      rx_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_filt_cnt;
  logic                   r_rx;
  logic                   w_rx_sync;

  assign w_rx_sync = r_sync[SYNC_STAGES-1];
  assign rx_o      = r_rx;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_pad_i};
    end
  end

  // The increment that would reach FILT_LEN toggles the line directly.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_filt_cnt <= '0;
      r_rx       <= 1'b1;
    end else if (w_rx_sync == r_rx) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == 4'(FILT_LEN - 1)) begin
      r_rx       <= w_rx_sync;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_uart_rx_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_uart_rx_frontend : line conditioning, break detect, char timeout  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module apb_uart_rx_frontend
  import apb_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int DIV_WIDTH   = 16
) (
  input wire logic              CLK,
  input wire logic              RESETN,
  apb_uart_rx_frontend_if.slave bus
);

  localparam logic [1:0]           c_st_idle  = S_IDLE;
  localparam logic [1:0]           c_st_low   = S_LOW;
  localparam logic [1:0]           c_st_break = S_BREAK;
  localparam logic [DIV_WIDTH-1:0] c_div_one  = DIV_WIDTH'(1);

  logic                 w_rx;
  logic                 r_rx_q;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_edge;
  logic [DIV_WIDTH-1:0] w_div;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 w_tick;
  logic [3:0]           w_fb;
  logic [5:0]           w_to_limit;
  logic [1:0]           r_state;
  logic [3:0]           r_low_cnt;
  logic                 r_break;
  logic [5:0]           r_to_cnt;
  logic                 r_cti;
  logic                 w_cti_clr;
  logic                 w_to_clr;

  apb_uart_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sync_filter (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .rx_pad_i (bus.rx_pad_i),
    .rx_o     (w_rx)
  );

  assign bus.rx_o    = w_rx;
  assign bus.break_o = r_break;
  assign bus.cti_o   = r_cti;

  assign w_rise     = ~r_rx_q & w_rx;
  assign w_fall     = r_rx_q & ~w_rx;
  assign w_edge     = w_rise | w_fall;
  assign w_div      = bus.cfg_div_i;
  assign w_fb       = frame_bits(bus.cfg_bits_i, bus.cfg_parity_en_i, bus.cfg_stop_bits_i);
  assign w_to_limit = 6'(CTI_CHARS) * {2'b00, w_fb};

  // >= rather than == keeps the divider sane when the divisor shrinks at runtime
  assign w_tick = (w_div != '0) && !w_edge && (r_div_cnt >= (w_div - c_div_one));

  assign w_cti_clr = bus.rx_fifo_empty_i | bus.rx_push_i | bus.rx_pop_i;
  assign w_to_clr  = w_cti_clr | ~w_rx;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_rx_q    <= 1'b1;
      r_div_cnt <= '0;
    end else begin
      r_rx_q <= w_rx;
      if ((w_div == '0) || w_edge || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + c_div_one;
      end
    end
  end

  // Clear is written first so a coincident set overrides it.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state   <= c_st_idle;
      r_low_cnt <= '0;
      r_break   <= 1'b0;
    end else begin
      if (bus.break_clr_i) begin
        r_break <= 1'b0;
      end
      case (r_state)
        c_st_idle: begin
          if (w_fall) begin
            r_state   <= c_st_low;
            r_low_cnt <= '0;
          end
        end
        c_st_low: begin
          if (w_rise) begin
            r_state <= c_st_idle;
          end else if (w_tick) begin
            r_low_cnt <= r_low_cnt + 4'd1;
            if ((r_low_cnt + 4'd1) >= w_fb) begin
              r_state <= c_st_break;
              r_break <= 1'b1;
            end
          end
        end
        c_st_break: begin
          if (w_rise) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_to_cnt <= '0;
      r_cti    <= 1'b0;
    end else begin
      if (w_to_clr) begin
        r_to_cnt <= '0;
      end else if (w_tick) begin
        r_to_cnt <= ((r_to_cnt + 6'd1) >= w_to_limit) ? w_to_limit : (r_to_cnt + 6'd1);
      end
      if (w_cti_clr) begin
        r_cti <= 1'b0;
      end else if (w_tick && !w_to_clr && ((r_to_cnt + 6'd1) >= w_to_limit)) begin
        r_cti <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/apb_uart_rx_frontend.md
Name: apb_uart_rx_frontend

Overview:
Receive-line conditioning stage sitting directly upstream of the UART receiver input. Per-clock flow:
- Synchronises the asynchronous serial pin.
- Rejects glitches shorter than a programmable number of clocks.
- Drives the cleaned line into the receiver's rx_i.
- Detects line break (line held low for longer than one full frame).
- Generates the 16550-style character-timeout indication consumed by the interrupt controller's CTI_i.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (minimum 2).
- FILT_LEN, 3, consecutive stable clocks required before the filtered line changes (1..15).
- DIV_WIDTH, 16, width of the bit-time divisor.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous active-low reset.
- rx_pad_i  in  1  raw serial input pin (asynchronous).
- cfg_div_i  in  DIV_WIDTH  clocks per bit time ({DLH,DLL}); 0 disables timing functions.
- cfg_bits_i  in  2  word length select: data bits = 5 + cfg_bits_i.
- cfg_parity_en_i  in  1  parity bit present.
- cfg_stop_bits_i  in  1  0 = 1 stop bit, 1 = 2 stop bits.
- rx_fifo_empty_i  in  1  RX FIFO empty flag.
- rx_push_i  in  1  RX FIFO write strobe (character received).
- rx_pop_i  in  1  RX FIFO read strobe (RBR read).
- break_clr_i  in  1  single-cycle clear of the sticky break flag (LSR read).
- rx_o  out  1  filtered line to the receiver.
- break_o  out  1  sticky break-detected flag.
- cti_o  out  1  character-timeout indication.

Behaviour:
- Clock and reset: single clock CLK; reset RESETN is asynchronous, active-low.
- Reset values: all synchroniser flops = 1; rx_o = 1; break_o = 0; cti_o = 0; all counters = 0; FSM = S_IDLE.
- Synchroniser: SYNC_STAGES-flop chain; its output is rx_sync.
- Filter:
  - Counter increments each clock while rx_sync != rx_o; it clears whenever rx_sync == rx_o.
  - When the counter reaches FILT_LEN, rx_o toggles and the counter clears.
  - Pad-edge-to-rx_o-edge latency = SYNC_STAGES + FILT_LEN clocks exactly (5 at defaults).
  - Pulses of ≤ FILT_LEN-1 clocks at rx_sync never reach rx_o.
- Bit-time tick:
  - Divider counts 0..cfg_div_i-1; bit_tick is asserted for one cycle when the count is ≥ cfg_div_i-1, then the divider wraps to 0. The ≥ comparison makes a runtime decrease of cfg_div_i safe.
  - The divider restarts at 0 on every rx_o edge, so ticks are aligned to start bits.
  - cfg_div_i = 0: no ticks; the break and timeout counters hold; break_o and cti_o keep their value apart from explicit clears.
- Frame length: frame_bits = 1 + (5 + cfg_bits_i) + cfg_parity_en_i + 1 + cfg_stop_bits_i, giving a range of 7..12. Use 4-bit arithmetic.
- Break FSM:
  - S_IDLE: on rx_o falling edge, go to S_LOW and clear the low-bit counter.
  - S_LOW: the low-bit counter increments on bit_tick.
    - rx_o rising: go to S_IDLE.
    - Counter reaches frame_bits: go to S_BREAK and set break_o.
  - S_BREAK: on rx_o rising edge, go to S_IDLE.
  - Only one break_o set per continuous low period.
  - break_clr_i clears break_o. When set and clear coincide, the set wins.
- Character timeout:
  - 6-bit counter, limit 4 × frame_bits (28..48).
  - The counter clears when any of these holds: rx_fifo_empty_i, rx_push_i, rx_pop_i, rx_o == 0.
  - Otherwise it increments on bit_tick, saturating at the limit.
  - cti_o sets when the counter reaches the limit.
  - cti_o clears on rx_pop_i, rx_push_i or rx_fifo_empty_i. These clears win over the set in the same cycle.
- Reset mid-operation: asynchronous return to the reset values, regardless of FSM state or the pad level. After release, a pad held low appears on rx_o after SYNC_STAGES + FILT_LEN clocks.

Decomposition:
- Shared package apb_uart_pkg holds:
  - line FSM enum (S_IDLE, S_LOW, S_BREAK);
  - function frame_bits(bits, pen, stb) returning 4 bits;
  - constant CTI_CHARS = 4.
- One natural sub-module: apb_uart_sync_filter (synchroniser plus glitch filter, parameters SYNC_STAGES and FILT_LEN). The tick, FSM and timeout logic stay in the top.

Test Plan:
- Glitch rejection: FILT_LEN=3; 2-clock low pulse on rx_pad_i → rx_o stays 1. 3-clock pulse → rx_o low for 3 clocks, first falling edge 5 clocks after the pad edge.
- Break detect: cfg_div_i=16, 8N1 (frame_bits=10); pad low for 170 clocks → break_o rises once about 160 clocks after rx_o falls and stays set. break_clr_i pulse while the line is still low → break_o=0 and does not re-set until a new low period.
- Set/clear collision: break_clr_i in the same cycle as the break set → break_o=1.
- Character timeout: cfg_div_i=4, 8N1, rx_fifo_empty_i=0, line idle → cti_o=1 after 40 ticks (about 160 clocks). rx_pop_i pulse → cti_o=0 next cycle and the count restarts.
- Timeout gating: rx_fifo_empty_i=1 for 500 clocks → cti_o stays 0. rx_push_i every 30 ticks → cti_o never asserts.
- Divisor zero / reset: cfg_div_i=0 with the pad held low for 1000 clocks → break_o=0, cti_o=0. RESETN asserted while in S_BREAK → break_o and cti_o = 0 and rx_o = 1 immediately (asynchronously); after release, rx_o falls after 5 clocks.
